// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: opcodes, forward selects,
// FSM states and the canonical NOP.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_FCC   = 7'b0001111;
    localparam logic [6:0] OP_CCC   = 7'b1110011;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_t;

    // M is the younger producer, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_M;
        else if (hit_w) return FWD_W;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_inst_regs.sv
// Per-stage instruction field decode: register indices and read/write usage flags.
module inst_regs
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic        o_writes_rd,
    output logic        o_uses_rs1,
    output logic        o_uses_rs2,
    output logic        o_is_load
);

    logic [6:0] w_op;

    assign w_op  = i_inst[6:0];
    assign o_rd  = i_inst[11:7];
    assign o_rs1 = i_inst[19:15];
    assign o_rs2 = i_inst[24:20];

    // An all-zero word is a killed slot, and x0 writes are architecturally void.
    assign o_writes_rd = !(w_op inside {OP_BCC, OP_SCC, OP_FCC, OP_CCC})
                         && (i_inst != 32'd0) && (o_rd != 5'd0);
    assign o_uses_rs1  = !(w_op inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign o_uses_rs2  = w_op inside {OP_BCC, OP_SCC, OP_RCC};
    assign o_is_load   = (w_op == OP_LCC);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: X-stage forwarding, D-stage write-through bypass,
// load-use stall and branch/jump flush sequencing with saturating event counters.
//
// state     | meaning
// RUN       | normal issue; a load-use inserts one stall cycle
// LD_STALL  | the load-use bubble is in flight; nothing asserted
// FLUSH     | killing wrong-path instructions after a taken branch/jump
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FLUSH_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_d,
    input  logic [31:0]      inst_x,
    input  logic [31:0]      inst_m,
    input  logic [31:0]      inst_w,
    input  logic             PCSel,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_x,
    output logic             flush_d,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             byp_d_rs1,
    output logic             byp_d_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int KW = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [KW-1:0] KILL_INIT = KW'(FLUSH_LEN - 1);

    logic [4:0] w_rd_d, w_rs1_d, w_rs2_d, w_rd_x, w_rs1_x, w_rs2_x;
    logic [4:0] w_rd_m, w_rs1_m, w_rs2_m, w_rd_w, w_rs1_w, w_rs2_w;
    logic       w_wr_d, w_u1_d, w_u2_d, w_ld_d;
    logic       w_wr_x, w_u1_x, w_u2_x, w_ld_x;
    logic       w_wr_m, w_u1_m, w_u2_m, w_ld_m;
    logic       w_wr_w, w_u1_w, w_u2_w, w_ld_w;
    logic       w_load_use;
    logic       w_unused;

    hz_state_t  r_state;
    logic [KW-1:0]    r_kill_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    inst_regs u_dec_d (
        .i_inst(inst_d), .o_rd(w_rd_d), .o_rs1(w_rs1_d), .o_rs2(w_rs2_d),
        .o_writes_rd(w_wr_d), .o_uses_rs1(w_u1_d), .o_uses_rs2(w_u2_d), .o_is_load(w_ld_d)
    );
    inst_regs u_dec_x (
        .i_inst(inst_x), .o_rd(w_rd_x), .o_rs1(w_rs1_x), .o_rs2(w_rs2_x),
        .o_writes_rd(w_wr_x), .o_uses_rs1(w_u1_x), .o_uses_rs2(w_u2_x), .o_is_load(w_ld_x)
    );
    inst_regs u_dec_m (
        .i_inst(inst_m), .o_rd(w_rd_m), .o_rs1(w_rs1_m), .o_rs2(w_rs2_m),
        .o_writes_rd(w_wr_m), .o_uses_rs1(w_u1_m), .o_uses_rs2(w_u2_m), .o_is_load(w_ld_m)
    );
    inst_regs u_dec_w (
        .i_inst(inst_w), .o_rd(w_rd_w), .o_rs1(w_rs1_w), .o_rs2(w_rs2_w),
        .o_writes_rd(w_wr_w), .o_uses_rs1(w_u1_w), .o_uses_rs2(w_u2_w), .o_is_load(w_ld_w)
    );

    // Decode fields that no hazard path looks at.
    assign w_unused = ^{w_rd_d, w_wr_d, w_ld_d, w_ld_m, w_ld_w, w_rs1_m, w_rs2_m,
                        w_u1_m, w_u2_m, w_rs1_w, w_rs2_w, w_u1_w, w_u2_w};

    assign fwd_a = fwd_sel(w_wr_m && (w_rd_m == w_rs1_x) && w_u1_x,
                           w_wr_w && (w_rd_w == w_rs1_x) && w_u1_x);
    assign fwd_b = fwd_sel(w_wr_m && (w_rd_m == w_rs2_x) && w_u2_x,
                           w_wr_w && (w_rd_w == w_rs2_x) && w_u2_x);

    assign byp_d_rs1 = w_wr_w && (w_rd_w == w_rs1_d) && w_u1_d;
    assign byp_d_rs2 = w_wr_w && (w_rd_w == w_rs2_d) && w_u2_d;

    assign w_load_use = w_ld_x && w_wr_x &&
                        ((w_u1_d && (w_rd_x == w_rs1_d)) || (w_u2_d && (w_rd_x == w_rs2_d)));

    // A taken branch/jump overrides everything, including a pending load-use.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        bubble_x = 1'b0;
        flush_d  = 1'b0;
        if (!reset) begin
            if (PCSel) begin
                flush_d  = 1'b1;
                bubble_x = 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_load_use) begin
                            stall_f  = 1'b1;
                            stall_d  = 1'b1;
                            bubble_x = 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        flush_d  = 1'b1;
                        bubble_x = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_kill_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (PCSel) begin
                r_kill_cnt <= KILL_INIT;
                r_state    <= (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN:      if (w_load_use) r_state <= ST_LD_STALL;
                    ST_LD_STALL: r_state <= ST_RUN;
                    ST_FLUSH: begin
                        if (r_kill_cnt <= KW'(1)) begin
                            r_kill_cnt <= '0;
                            r_state    <= ST_RUN;
                        end else begin
                            r_kill_cnt <= r_kill_cnt - KW'(1);
                        end
                    end
                    default:     r_state <= ST_RUN;
                endcase
            end
            if (stall_f && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_d && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
